// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with frame-synchronised loading,
// leading-zero suppression, per-digit blink and PWM brightness.
module seg_scan_display #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV_W  = 17,
    parameter int BLINK_DIV_W = 25
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   Hexs,
    input  logic [DIGITS-1:0]     Points,
    input  logic [DIGITS-1:0]     LES,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_blank,
    input  logic [2:0]            bright,
    input  logic                  load,
    output logic                  update_ack,
    output logic                  frame_sync,
    output logic [7:0]            Segment,
    output logic [DIGITS-1:0]     AN
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [SCAN_DIV_W-1:0]  scan_q, scan_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BLINK_DIV_W-1:0] bcnt_q, bcnt_d;
    logic                   phase_q, phase_d;
    logic [4*DIGITS-1:0]    pend_hex_q, pend_hex_d;
    logic [DIGITS-1:0]      pend_pt_q, pend_pt_d;
    logic                   pend_v_q, pend_v_d;
    logic [4*DIGITS-1:0]    act_hex_q, act_hex_d;
    logic [DIGITS-1:0]      act_pt_q, act_pt_d;
    logic [7:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic                   ack_q, ack_d;
    logic                   fs_q, fs_d;

    logic       slot_end, wrap;
    logic [3:0] nib;
    logic       pt, dk_les, dk_bl, upper_zero, dark, supp;
    logic [6:0] seg7;

    always_comb begin
        slot_end   = &scan_q;
        wrap       = slot_end && (idx_q == LAST);
        scan_d     = scan_q + 1'b1;
        idx_d      = idx_q;
        if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;
        bcnt_d     = bcnt_q + 1'b1;
        phase_d    = phase_q ^ (&bcnt_q);

        // apply reads the old pending copy; a same-cycle load stays pending
        pend_hex_d = pend_hex_q;
        pend_pt_d  = pend_pt_q;
        pend_v_d   = pend_v_q;
        act_hex_d  = act_hex_q;
        act_pt_d   = act_pt_q;
        if (wrap && pend_v_q) begin
            act_hex_d = pend_hex_q;
            act_pt_d  = pend_pt_q;
            pend_v_d  = 1'b0;
        end
        if (load) begin
            pend_hex_d = Hexs;
            pend_pt_d  = Points;
            pend_v_d   = 1'b1;
        end
        fs_d  = wrap;
        ack_d = wrap && pend_v_q;

        nib        = '0;
        pt         = 1'b0;
        dk_les     = 1'b0;
        dk_bl      = 1'b0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_q) begin
                nib    = act_hex_q[4*j +: 4];
                pt     = act_pt_q[j];
                dk_les = LES[j];
                dk_bl  = blink[j];
            end
            if (IW'(j) >= idx_q && act_hex_q[4*j +: 4] != 4'h0) upper_zero = 1'b0;
            if (IW'(j) > idx_q && act_pt_q[j]) upper_zero = 1'b0;
        end

        dark = dk_les || (dk_bl && phase_q)
            || (scan_q[SCAN_DIV_W-1 -: 3] > bright);
        supp = lz_blank && (idx_q != '0) && upper_zero;

        case (nib)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase

        seg_d = 8'hFF;
        an_d  = '1;
        if (!dark) begin
            seg_d = {~pt, supp ? 7'h7F : seg7};
            an_d  = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            scan_q     <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
            pend_hex_q <= '0;
            pend_pt_q  <= '0;
            pend_v_q   <= 1'b0;
            act_hex_q  <= '0;
            act_pt_q   <= '0;
            seg_q      <= 8'hFF;
            an_q       <= '1;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            pend_hex_q <= pend_hex_d;
            pend_pt_q  <= pend_pt_d;
            pend_v_q   <= pend_v_d;
            act_hex_q  <= act_hex_d;
            act_pt_q   <= act_pt_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
        end
    end

    assign Segment    = seg_q;
    assign AN         = an_q;
    assign update_ack = ack_q;
    assign frame_sync = fs_q;

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised time-multiplexed seven-segment driver, successor to the fixed 4-digit scanner. Drives DIGITS common-anode digits from a packed hex word. Adds:
- tear-free frame-synchronised value loading with a handshake;
- leading-zero suppression;
- per-digit blink;
- 8-level PWM brightness.

Sits between application logic and the board segment/anode pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV_W, 17, scan counter width; one digit slot = 2^SCAN_DIV_W clk cycles (must be >= 4)
BLINK_DIV_W, 25, blink counter width; blink phase toggles every 2^BLINK_DIV_W clk cycles

Ports:
clk  in  1  system clock
RST  in  1  asynchronous reset, active-high
Hexs  in  4*DIGITS  digit values; nibble i = digit i, digit 0 rightmost
Points  in  DIGITS  decimal point per digit, 1 = lit
LES  in  DIGITS  per-digit blank enable, 1 = digit fully dark
blink  in  DIGITS  per-digit blink enable
lz_blank  in  1  1 = suppress leading zeros
bright  in  3  brightness, 0 = 1/8 duty .. 7 = full duty
load  in  1  single-cycle request to capture Hexs/Points
update_ack  out  1  one-cycle pulse when captured values become displayed
frame_sync  out  1  one-cycle pulse at each scan wrap (digit DIGITS-1 -> 0)
Segment  out  8  {p,g,f,e,d,c,b,a}, active-low
AN  out  DIGITS  anode select, active-low, one-hot-low

Behaviour:
- Clock and reset: one clock domain (clk). RST asynchronous, active-high.
- Reset values:
  - Segment = 8'hFF, AN = all ones, update_ack = 0, frame_sync = 0.
  - Scan counter, blink counter, digit index, blink phase = 0.
  - Pending regs, active regs, pending_valid = 0.
  - RST asserted mid-frame clears all of the above immediately; pins go dark in the same cycle.
- Scan counter:
  - Free-running, SCAN_DIV_W bits.
  - slot_end = counter all ones.
  - On slot_end, digit index increments. Wrap occurs when index = DIGITS-1: index returns to 0 and frame_sync pulses the next cycle.
- Load handshake:
  - load = 1 copies Hexs/Points into pending regs and sets pending_valid.
  - A repeated load before apply overwrites the pending regs (latest wins); only one ack is issued.
  - On wrap with pending_valid = 1: pending copied to active, pending_valid cleared, update_ack pulses the next cycle (coincident with frame_sync).
  - load in the same cycle as wrap: that cycle's apply uses the old pending contents; the new data stays pending (pending_valid remains 1) and is applied at the following wrap.
  - Displayed digits never mix two loads within a frame.
  - LES, blink, lz_blank and bright are live inputs, not shadowed.
- Brightness: digit driven only while scan counter top 3 bits <= bright; otherwise AN = all ones and Segment = 8'hFF.
- Blink:
  - Phase toggles when the blink counter is all ones.
  - Digit i dark while blink[i] = 1 and phase = 1.
- Leading-zero suppression (lz_blank = 1):
  - Digit i (i > 0) is suppressed when active nibbles i..DIGITS-1 are all 0 and active Points i+1..DIGITS-1 are all 0.
  - A suppressed digit shows segments off but still shows its own point if set.
  - Digit 0 is never suppressed, so value 0 displays "0".
- Darkening priority: RST > LES > blink > brightness > suppression.
  - Dark (LES, blink or brightness): AN bit for the digit stays 1 (inactive), Segment = 8'hFF.
  - Suppressed: AN active, segments a..g off.
- Decode, active-low {g..a}:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - p bit = ~Points[i].
- Latency: Segment and AN are registered; 1 cycle after the counter/index state that selects them.

Test Plan:
- All tests use DIGITS=4, SCAN_DIV_W=4, BLINK_DIV_W=8.
- Reset: RST high mid-scan -> Segment=8'hFF, AN=4'hF, update_ack=0 in the same cycle. Release -> digit 0 selected (AN=4'hE) from the next cycle.
- Load + scan: load Hexs=16'h12AF, Points=4'b0100, bright=7 -> after the next frame_sync, update_ack pulses once. Within each frame (16 clk slots): AN=E/Segment=8E, AN=D/Segment=88, AN=B/Segment=24 (point lit), AN=7/Segment=F9.
- Tear-free apply: load 16'h1111 then 16'h2222 mid-frame, and load 16'h3333 on the wrap cycle -> next frame shows all 2s, following frame shows all 3s. Exactly two update_ack pulses.
- Leading zeros: lz_blank=1, Hexs=16'h0005 -> digits 3..1 AN active with Segment=8'hFF, digit 0 shows 92. With Hexs=16'h0000 only digit 0 lights, showing C0. With Points=4'b0100, digit 2 shows 7F and digit 1 shows C0.
- Brightness/blink: bright=0 -> each AN low for exactly 2 of 16 slot cycles. blink=4'b0001 -> digit 0 alternately lit/dark every 256 clk. LES=4'b1000 -> AN[3] never 0.
